kv_append_packer: RTL and testbench

KV_APPEND_PACKER -- requirements
Module: kv_append_packer

---
 rtl/kv_append_packer.sv | 147 ++++++++++++++
 tb/tb_kv_append_packer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kv_append_packer.sv
// Packs a head-major element stream into HEAD_DIM-wide vectors and issues one
// KV-cache append per head; all heads of a job target the same sequence position.
module kv_append_packer #(
    parameter int MAX_LAYERS = 4,
    parameter int MAX_HEADS  = 4,
    parameter int MAX_SEQ    = 512,
    parameter int HEAD_DIM   = 16,
    parameter int DW         = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(MAX_LAYERS)-1:0] cfg_layer,
    input  logic [$clog2(MAX_SEQ)-1:0]    cfg_time,
    input  logic                          cfg_is_v,
    input  logic [$clog2(MAX_HEADS):0]    cfg_num_heads,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DW-1:0]                 in_data,
    output logic                          append_valid,
    input  logic                          append_ready,
    output logic [$clog2(MAX_LAYERS)-1:0] append_layer,
    output logic [$clog2(MAX_HEADS)-1:0]  append_head,
    output logic [$clog2(MAX_SEQ)-1:0]    append_time,
    output logic                          append_is_v,
    output logic [HEAD_DIM*DW-1:0]        append_data,
    input  logic                          append_done,
    output logic                          busy,
    output logic                          done
);

    localparam int LW  = $clog2(MAX_LAYERS);
    localparam int HW  = $clog2(MAX_HEADS);
    localparam int TW  = $clog2(MAX_SEQ);
    localparam int NHW = HW + 1;
    localparam int CW  = (HEAD_DIM > 1) ? $clog2(HEAD_DIM) : 1;
    localparam logic [NHW-1:0] NH_MAX = NHW'(MAX_HEADS);

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT_DONE} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_elem_cnt;
    logic [HW-1:0]          r_head_cnt;
    logic [NHW-1:0]         r_num_heads;
    logic [LW-1:0]          r_layer;
    logic [TW-1:0]          r_time;
    logic                   r_is_v;
    logic [HEAD_DIM*DW-1:0] r_buf;
    logic                   r_in_ready;
    logic                   r_append_valid;
    logic                   r_busy;
    logic                   r_done;

    logic [NHW-1:0]         w_nh_clamped;
    logic                   w_accept;
    logic                   w_last_elem;
    logic                   w_last_head;

    assign w_nh_clamped = (cfg_num_heads > NH_MAX) ? NH_MAX : cfg_num_heads;
    assign w_accept     = in_valid && r_in_ready;
    assign w_last_elem  = (r_elem_cnt == CW'(HEAD_DIM - 1));
    assign w_last_head  = ({1'b0, r_head_cnt} == (r_num_heads - NHW'(1)));

    // Outputs come straight from registers, so the append fields stay frozen
    // from ISSUE through WAIT_DONE while the cache samples them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_elem_cnt     <= '0;
            r_head_cnt     <= '0;
            r_num_heads    <= '0;
            r_layer        <= '0;
            r_time         <= '0;
            r_is_v         <= 1'b0;
            r_buf          <= '0;
            r_in_ready     <= 1'b0;
            r_append_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_layer     <= cfg_layer;
                        r_time      <= cfg_time;
                        r_is_v      <= cfg_is_v;
                        r_num_heads <= w_nh_clamped;
                        r_elem_cnt  <= '0;
                        r_head_cnt  <= '0;
                        if (w_nh_clamped == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state    <= FILL;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        r_buf[r_elem_cnt*DW +: DW] <= in_data;
                        if (w_last_elem) begin
                            r_elem_cnt     <= '0;
                            r_in_ready     <= 1'b0;
                            r_append_valid <= 1'b1;
                            r_state        <= ISSUE;
                        end else begin
                            r_elem_cnt <= r_elem_cnt + CW'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (append_ready) begin
                        r_append_valid <= 1'b0;
                        r_state        <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (append_done) begin
                        if (w_last_head) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_head_cnt <= r_head_cnt + HW'(1);
                            r_in_ready <= 1'b1;
                            r_state    <= FILL;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign append_valid = r_append_valid;
    assign append_layer = r_layer;
    assign append_head  = r_head_cnt;
    assign append_time  = r_time;
    assign append_is_v  = r_is_v;
    assign append_data  = r_buf;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_kv_append_packer.sv
// Scoreboard bench for kv_append_packer: jobs push expected head vectors,
// a monitor process pops and compares on every append handshake.
module tb_kv_append_packer;

    localparam int ML = 4;
    localparam int MH = 4;
    localparam int MS = 512;
    localparam int HD = 16;
    localparam int DW = 8;
    localparam int VW = HD * DW;
    localparam int XW = 160;

    typedef struct {
        logic [1:0]    layer;
        logic [1:0]    head;
        logic [8:0]    tm;
        logic          isv;
        logic [VW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start;
    logic [1:0]    cfg_layer;
    logic [8:0]    cfg_time;
    logic          cfg_is_v;
    logic [2:0]    cfg_num_heads;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          append_valid;
    logic          append_ready;
    logic [1:0]    append_layer;
    logic [1:0]    append_head;
    logic [8:0]    append_time;
    logic          append_is_v;
    logic [VW-1:0] append_data;
    logic          append_done;
    logic          busy;
    logic          done;

    logic          dd;
    logic          spur_done;
    assign append_done = dd | spur_done;

    exp_t       exp_q[$];
    logic [7:0] elems[64];
    int         n_vec;
    int         n_err;
    int         n_app;
    int         cyc;
    int         stall_cfg;
    int         done_dly;

    always #5 clk = ~clk;

    kv_append_packer #(
        .MAX_LAYERS(ML), .MAX_HEADS(MH), .MAX_SEQ(MS), .HEAD_DIM(HD), .DW(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_layer(cfg_layer), .cfg_time(cfg_time), .cfg_is_v(cfg_is_v),
        .cfg_num_heads(cfg_num_heads),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .append_valid(append_valid), .append_ready(append_ready),
        .append_layer(append_layer), .append_head(append_head),
        .append_time(append_time), .append_is_v(append_is_v),
        .append_data(append_data), .append_done(append_done),
        .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_append_valid"}, append_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_append_fields"}, {append_layer, append_head, append_time, append_is_v}, 0);
        chk({tag, "_append_data"}, append_data, 0);
    endtask

    // Cache-side responder and checker: drives append_ready/append_done and
    // compares every handshake against the scoreboard head.
    task automatic monitor_loop();
        int         scnt = 0;
        int         dd_cnt = -1;
        bit         hs;
        bit         hs_prev = 0;
        bit         stall_prev = 0;
        logic [141:0] saved = '0;
        logic [141:0] cur;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dd = 1'b0;
                dd_cnt = -1;
                scnt = 0;
                hs_prev = 0;
                stall_prev = 0;
                append_ready = (stall_cfg == 0);
            end else begin
                cur = {append_layer, append_head, append_time, append_is_v, append_data};
                if (stall_prev) begin
                    chk("stall_valid_held", append_valid, 1);
                    chk("stall_fields_held", cur, saved);
                end
                if (hs_prev)
                    chk("post_handshake_fields_held", cur, saved);
                if (append_valid)
                    chk("in_ready_low_while_issuing", in_ready, 0);
                if (dd_cnt == 0) begin
                    dd = 1'b1;
                    dd_cnt = -1;
                end else begin
                    dd = 1'b0;
                    if (dd_cnt > 0) dd_cnt--;
                end
                if (append_valid) begin
                    if (scnt < stall_cfg) begin
                        scnt++;
                        append_ready = 1'b0;
                    end else begin
                        append_ready = 1'b1;
                    end
                end else begin
                    scnt = 0;
                    append_ready = (stall_cfg == 0);
                end
                hs = append_valid && append_ready;
                if (hs) begin
                    n_app++;
                    chk("append_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("append_layer", append_layer, e.layer);
                        chk("append_head", append_head, e.head);
                        chk("append_time", append_time, e.tm);
                        chk("append_is_v", append_is_v, e.isv);
                        chk("append_data", append_data, e.data);
                    end
                    dd_cnt = done_dly;
                    scnt = 0;
                end
                stall_prev = append_valid && !append_ready;
                hs_prev = hs;
                saved = cur;
            end
        end
    endtask

    task automatic feed(input int total, input int pct, input int glitch);
        int idx = 0;
        int guard = 0;
        bit glitched = 0;
        bit tog = 0;
        while (idx < total && guard < 4000) begin
            @(posedge clk); #1;
            start = 1'b0;
            spur_done = 1'b0;
            if (glitch >= 0 && idx == glitch && !glitched) begin
                glitched = 1;
                start = 1'b1;
                spur_done = 1'b1;
                cfg_layer = cfg_layer + 2'd1;
                cfg_time = cfg_time + 9'd5;
                cfg_is_v = ~cfg_is_v;
                cfg_num_heads = 3'd1;
            end
            tog = ~tog;
            in_valid = (pct < 0) ? tog : (int'($urandom_range(99)) < pct);
            in_data = elems[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            guard++;
        end
        chk("feed_complete", idx, total);
        @(posedge clk); #1;
        in_valid = 1'b0;
        start = 1'b0;
        spur_done = 1'b0;
    endtask

    // partial >= 0 stops after that many elements; base < 0 means random data.
    task automatic run_job(input int layer, input int tm, input int isv, input int nh,
                           input int pct, input int stall, input int dly, input int glitch,
                           input int partial, input int base, input int lat);
        int   nh_eff;
        int   total;
        int   app0;
        int   t0;
        int   extra;
        bit   seen;
        exp_t e;
        nh_eff = (nh > MH) ? MH : nh;
        total = (partial >= 0) ? partial : nh_eff * HD;
        for (int i = 0; i < 64; i++)
            elems[i] = (base < 0) ? 8'($urandom_range(255)) : 8'(i + base);
        for (int h = 0; h < nh_eff; h++) begin
            if ((h + 1) * HD <= total) begin
                e.layer = 2'(layer);
                e.head = 2'(h);
                e.tm = 9'(tm);
                e.isv = 1'(isv);
                e.data = '0;
                for (int d = 0; d < HD; d++) e.data[d*DW +: DW] = elems[h*HD + d];
                exp_q.push_back(e);
            end
        end
        stall_cfg = stall;
        done_dly = dly;
        app0 = n_app;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_layer = 2'(layer);
        cfg_time = 9'(tm);
        cfg_is_v = 1'(isv);
        cfg_num_heads = 3'(nh);
        t0 = cyc;
        if (total > 0) begin
            feed(total, pct, glitch);
        end else begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (partial >= 0) return;
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk); #1;
            if (done) seen = 1;
        end
        chk("done_pulse", seen, 1);
        if (lat > 0) chk("done_latency", cyc - t0, lat);
        chk("busy_at_done", busy, 0);
        chk("append_count", n_app - app0, nh_eff);
        chk("scoreboard_drained", exp_q.size(), 0);
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (done) extra++;
        end
        chk("done_single_pulse", extra, 0);
    endtask

    initial begin
        int app_before;
        n_vec = 0; n_err = 0; n_app = 0; cyc = 0;
        start = 1'b0; cfg_layer = '0; cfg_time = '0; cfg_is_v = 1'b0; cfg_num_heads = '0;
        in_valid = 1'b0; in_data = '0; dd = 1'b0; spur_done = 1'b0; append_ready = 1'b1;
        stall_cfg = 0; done_dly = 0;
        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single head, known pattern, minimum latency
        run_job(2, 37, 1, 1, 100, 0, 0, -1, -1, 1, 19);
        // four K heads at the last position, continuous stream
        run_job(1, 511, 0, 4, 100, 0, 0, -1, -1, 0, 4 * (HD + 2) + 1);
        // alternating in_valid with a five-cycle append stall per head
        run_job(1, 511, 0, 4, -1, 5, 0, -1, -1, 0, 0);
        // zero heads, then clamp of 7 heads to four
        run_job(3, 200, 1, 0, 100, 0, 0, -1, -1, -1, 1);
        run_job(0, 12, 1, 7, 100, 0, 0, -1, -1, -1, 4 * (HD + 2) + 1);
        // start pulse and spurious append_done while filling
        run_job(2, 300, 0, 2, 100, 0, 0, 5, -1, -1, 2 * (HD + 2) + 1);

        // reset after nine elements of head 1
        app_before = n_app;
        run_job(3, 100, 1, 4, 100, 0, 0, -1, HD + 9, -1, 0);
        rst_n = 1'b0;
        #1;
        chk_zero("midjob_reset");
        chk("midjob_appends_before_reset", n_app - app_before, 1);
        chk("midjob_scoreboard", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk_zero("held_reset");
        rst_n = 1'b1;
        run_job(1, 45, 0, 1, 100, 0, 0, -1, -1, -1, 19);

        for (int j = 0; j < 10; j++)
            run_job(int'($urandom_range(3)), int'($urandom_range(511)), int'($urandom_range(1)),
                    int'($urandom_range(7)), int'($urandom_range(100, 40)), int'($urandom_range(3)),
                    int'($urandom_range(3)), -1, -1, -1, 0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
